// File: rtl/adder_slice_sched_if.sv
// Bundles the two requester channels, the response channel and the shared
// 3-bit adder slice connection.
interface adder_slice_sched_if #(
   parameter int unsigned WIDTH = 12
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_cin;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_cin;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;

   logic [2:0]       slc_a;
   logic [2:0]       slc_b;
   logic             slc_cin;
   logic [2:0]       slc_sum;
   logic             slc_cout;

   // Environment side: requesters, response consumer and the adder slice.
   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_cin,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
      output rsp_ready,
      input  slc_a, slc_b, slc_cin,
      output slc_sum, slc_cout
   );

   // Scheduler side.
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_cin,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout,
      input  rsp_ready,
      output slc_a, slc_b, slc_cin,
      input  slc_sum, slc_cout
   );
endinterface

// File: rtl/adder_slice_sched.sv
// Round-robin scheduler that time-shares one external 3-bit ripple adder slice
// between two requesters, executing each WIDTH-bit add LSB chunk first.
module adder_slice_sched #(
   parameter int unsigned WIDTH = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   adder_slice_sched_if.slave bus
);
   localparam int unsigned NCHUNK = WIDTH / 3;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             last_grant;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_sum_q;
   logic             rsp_cout_q;
   logic             gnt0;
   logic             gnt1;

   // Grants only in IDLE; on a tie the requester not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && state == IDLE) begin
         gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant);
         gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
      end
   end

   // Operand registers shift right each chunk, so the active chunk is always bits [2:0].
   always_comb begin
      bus.slc_a   = 3'd0;
      bus.slc_b   = 3'd0;
      bus.slc_cin = 1'b0;
      if (state == RUN) begin
         bus.slc_a   = a_reg[2:0];
         bus.slc_b   = b_reg[2:0];
         bus.slc_cin = carry;
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_sum    = rsp_sum_q;
   assign bus.rsp_cout   = rsp_cout_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         last_grant  <= 1'b1;
         a_reg       <= '0;
         b_reg       <= '0;
         carry       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  a_reg      <= gnt1 ? bus.req1_a   : bus.req0_a;
                  b_reg      <= gnt1 ? bus.req1_b   : bus.req0_b;
                  carry      <= gnt1 ? bus.req1_cin : bus.req0_cin;
                  rsp_id_q   <= gnt1;
                  last_grant <= gnt1;
                  idx        <= '0;
                  state      <= RUN;
               end
            end
            RUN: begin
               // Each chunk result enters at the top; after NCHUNK shifts it is in place.
               a_reg     <= a_reg >> 3;
               b_reg     <= b_reg >> 3;
               carry     <= bus.slc_cout;
               rsp_sum_q <= (rsp_sum_q >> 3) | (WIDTH'(bus.slc_sum) << (WIDTH - 3));
               if (idx == LAST_IDX) begin
                  idx         <= '0;
                  rsp_cout_q  <= bus.slc_cout;
                  rsp_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
